// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU: datapath width and the 3-bit
// operation codes. The ALU control decoder and the ALU both import this
// package, so the encoding is defined in one place only.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH = 32;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND  = 3'd0;
    localparam alu_ctrl_t ALU_OR   = 3'd1;
    localparam alu_ctrl_t ALU_ADD  = 3'd2;  // signed add, reports overflow
    localparam alu_ctrl_t ALU_SLT  = 3'd3;
    localparam alu_ctrl_t ALU_ADDU = 3'd4;  // unsigned add, never reports overflow
    localparam alu_ctrl_t ALU_SLL  = 3'd5;
    localparam alu_ctrl_t ALU_SUB  = 3'd6;  // also used by beq/bne via ze
    localparam alu_ctrl_t ALU_SLTU = 3'd7;

    // Operations that route through the adder in subtract mode.
    function automatic logic uses_subtract(alu_ctrl_t ctrl);
        return (ctrl == ALU_SUB) || (ctrl == ALU_SLT) || (ctrl == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Operand/result bundle between the EX-stage operand muxes and the ALU.
//   ctrl       operation select (alu_pkg codes)
//   A, B       operands (rs, rt or extended immediate)
//   shamt      shift amount for SLL
//   R          result
//   cout       carry out of bit 31 (ADD/ADDU/SUB only)
//   ovf        signed overflow (ADD/SUB only)
//   ze         R == 0
//   ovf_sticky latched overflow status
// master: the pipeline side that drives operands; slave: the ALU.
// -----------------------------------------------------------------------------
interface alu_if;
    import alu_pkg::*;

    alu_ctrl_t          ctrl;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [4:0]         shamt;
    logic [WIDTH-1:0]   R;
    logic               cout;
    logic               ovf;
    logic               ze;
    logic               ovf_sticky;

    modport master (
        output ctrl, A, B, shamt,
        input  R, cout, ovf, ze, ovf_sticky
    );

    modport slave (
        input  ctrl, A, B, shamt,
        output R, cout, ovf, ze, ovf_sticky
    );
endinterface

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// WIDTH-bit adder with a subtract control. With sub = 1 it computes
// a + ~b + 1, so cout = 1 means "no borrow" (a >= b unsigned).
//   a, b   operands
//   sub    1 selects a - b
//   sum    result modulo 2^WIDTH
//   cout   carry out of the MSB
//   ovf    signed overflow of the operation actually performed
// -----------------------------------------------------------------------------
module alu_addsub
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff         = sub ? ~b : b;
    assign {cout, sum}   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    // Overflow when both effective operands share a sign and the sum does not.
    // In subtract mode b_eff[MSB] = ~b[MSB], which gives the a/b sign-differ rule.
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// 32-bit integer ALU for the EX stage of the MIPS-subset pipeline.
// R, cout, ovf and ze are purely combinational from ctrl/A/B/shamt.
//   clk   rising-edge clock, used only by the sticky-overflow register
//   rst   synchronous active-high reset for the sticky-overflow register
//   bus   alu_if.slave: operands in, result and flags out
// Build option: define ALU_STICKY_OVF_EN to get a sticky overflow register
// (set by ovf, cleared only by rst). Without it ovf_sticky is tied to 0 and
// clk/rst are unused.
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_ovf;
    logic             sub;

    logic [WIDTH-1:0] result;
    logic             cout_o;
    logic             ovf_o;
    logic             slt_bit;

    assign sub = uses_subtract(bus.ctrl);

    alu_addsub u_addsub (
        .a    (bus.A),
        .b    (bus.B),
        .sub  (sub),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

    // Signed less-than that stays correct when A - B overflows:
    // differing signs decide by A's sign, otherwise the difference sign is exact.
    assign slt_bit = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) ? bus.A[WIDTH-1]
                                                        : as_sum[WIDTH-1];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        result = '0;
        cout_o = 1'b0;
        ovf_o  = 1'b0;
        case (bus.ctrl)
            ALU_AND:  result = bus.A & bus.B;
            ALU_OR:   result = bus.A | bus.B;
            ALU_ADD: begin
                result = as_sum;
                cout_o = as_cout;
                ovf_o  = as_ovf;
            end
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_ADDU: begin
                result = as_sum;
                cout_o = as_cout;
            end
            ALU_SLL:  result = bus.B << bus.shamt;
            ALU_SUB: begin
                result = as_sum;
                cout_o = as_cout;
                ovf_o  = as_ovf;
            end
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, ~as_cout};
            default:  result = '0;
        endcase
    end

    assign bus.R    = result;
    assign bus.cout = cout_o;
    assign bus.ovf  = ovf_o;
    assign bus.ze   = ~|result;

`ifdef ALU_STICKY_OVF_EN
    logic ovf_sticky_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;   // rst wins over a simultaneous overflow
        end else if (ovf_o) begin
            ovf_sticky_q <= 1'b1;
        end
    end

    assign bus.ovf_sticky = ovf_sticky_q;
`else
    // Register not built; clk/rst stay on the port list for a uniform pinout.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign bus.ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Scoreboard bench for alu. The driver applies one operand set per clock
// (just after the rising edge), computes the expected response from a plain
// arithmetic reference model and pushes it into a queue. The monitor samples
// the DUT on the falling edge and compares against the popped entry.
// The sticky flag model follows the ALU_STICKY_OVF_EN build option.
// -----------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic        cout;
        logic        ovf;
        logic        ze;
        logic        sticky;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic model_sticky = 1'b0;
    logic prev_rst     = 1'b1;
    logic prev_ovf     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [2:0] ctrl, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint sx;
        logic [32:0] wide;
        e.r    = '0;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        sx     = 0;
        wide   = {1'b0, a} + {1'b0, b};
        case (ctrl)
            3'd0: e.r = a & b;
            3'd1: e.r = a | b;
            3'd2: begin
                e.r    = a + b;
                e.cout = wide[32];
                sx     = longint'($signed(a)) + longint'($signed(b));
                e.ovf  = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
            end
            3'd3: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: begin
                e.r    = a + b;
                e.cout = wide[32];
            end
            3'd5: e.r = b << sh;
            3'd6: begin
                e.r    = a - b;
                e.cout = (a >= b);
                sx     = longint'($signed(a)) - longint'($signed(b));
                e.ovf  = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
            end
            default: e.r = (a < b) ? 32'd1 : 32'd0;
        endcase
        e.ze = (e.r == 32'd0);
        return e;
    endfunction

    task automatic apply(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic r, input string name);
        exp_t e;
        @(posedge clk);
`ifdef ALU_STICKY_OVF_EN
        if (prev_rst)      model_sticky = 1'b0;
        else if (prev_ovf) model_sticky = 1'b1;
`else
        model_sticky = 1'b0;
`endif
        #1;
        bus.ctrl  = ctrl;
        bus.A     = a;
        bus.B     = b;
        bus.shamt = sh;
        rst       = r;
        e         = model(ctrl, a, b, sh);
        e.sticky  = model_sticky;
        e.name    = name;
        exp_q.push_back(e);
        prev_rst  = r;
        prev_ovf  = e.ovf;
    endtask

    // Monitor: outputs are combinational, so each cycle's vector is observed
    // on the falling edge after it was applied.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".R"},      bus.R,                   e.r);
                check({e.name, ".cout"},   {31'd0, bus.cout},       {31'd0, e.cout});
                check({e.name, ".ovf"},    {31'd0, bus.ovf},        {31'd0, e.ovf});
                check({e.name, ".ze"},     {31'd0, bus.ze},         {31'd0, e.ze});
                check({e.name, ".sticky"}, {31'd0, bus.ovf_sticky}, {31'd0, e.sticky});
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.ctrl  = ALU_AND;
        bus.A     = '0;
        bus.B     = '0;
        bus.shamt = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state (rst still high on this vector's preceding edge).
        apply(ALU_AND,  32'h0,         32'h0,         5'd0,  1'b0, "reset");
        // Directed corner cases.
        apply(ALU_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0,  1'b0, "add_ovf");
        apply(ALU_ADDU, 32'hFFFF_FFFF, 32'h1,         5'd0,  1'b0, "addu_wrap");
        apply(ALU_SUB,  32'd5,         32'd5,         5'd0,  1'b0, "sub_eq");
        apply(ALU_SUB,  32'd3,         32'd5,         5'd0,  1'b0, "sub_borrow");
        apply(ALU_SLT,  32'h8000_0000, 32'h1,         5'd0,  1'b0, "slt_neg");
        apply(ALU_SLTU, 32'h8000_0000, 32'h1,         5'd0,  1'b0, "sltu_big");
        apply(ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 5'd0,  1'b0, "slt_ovfdiff");
        apply(ALU_SLL,  32'hDEAD_BEEF, 32'h3,         5'd4,  1'b0, "sll_4");
        apply(ALU_SLL,  32'h0,         32'h1,         5'd31, 1'b0, "sll_31");
        apply(ALU_SLL,  32'h1234_5678, 32'hCAFE_F00D, 5'd0,  1'b0, "sll_0");
        apply(ALU_AND,  32'hF0F0,      32'hFF00,      5'd0,  1'b0, "and");
        apply(ALU_OR,   32'hF0F0,      32'hFF00,      5'd0,  1'b0, "or");
        apply(ALU_SUB,  32'h8000_0000, 32'h1,         5'd0,  1'b0, "sub_ovf");
        // Sticky: set, then reset together with an overflow, then idle.
        apply(ALU_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0,  1'b0, "stk_set");
        apply(ALU_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0,  1'b1, "stk_rst_ovf");
        apply(ALU_AND,  32'h0,         32'h0,         5'd0,  1'b0, "stk_cleared");
        apply(ALU_OR,   32'h1,         32'h2,         5'd0,  1'b0, "stk_hold0");
        apply(ALU_ADDU, 32'h1,         32'h2,         5'd0,  1'b0, "stk_hold0b");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            apply(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  5'($urandom_range(0, 31)), ($urandom_range(0, 15) == 0), "rand");
        end

        // Drain: the monitor must consume every pushed entry within a few cycles.
        for (int c = 0; c < 4 && exp_q.size() > 0; c++) @(posedge clk);
        check("drain_left", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the five-stage MIPS-subset pipeline; sits in EX between the ALUSrc mux and the EX/MEM register.
- Computes the result and the flags cout, ovf and ze combinationally from a 3-bit control code.
- ze feeds the beq/bne resolution; R[31] serves as the sign for bgtz.
- clk and rst serve only the optional sticky-overflow status register.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ctrl  in  3  operation select
- A  in  32  operand A (rs)
- B  in  32  operand B (rt or extended immediate)
- shamt  in  5  shift amount
- R  out  32  result
- cout  out  1  carry out of bit 31
- ovf  out  1  signed overflow
- ze  out  1  1 when R == 0
- ovf_sticky  out  1  latched overflow status

Behaviour:
- R, cout, ovf and ze are purely combinational: zero latency, no dependence on clk or rst.
- ctrl encoding:
  - 0 AND: R = A & B
  - 1 OR: R = A | B
  - 2 ADD (signed): R = A + B
  - 3 SLT (signed): R = {31'b0, A <s B}
  - 4 ADDU: R = A + B
  - 5 SLL: R = B << shamt, zero fill
  - 6 SUB: R = A - B, computed as A + ~B + 1
  - 7 SLTU: R = {31'b0, A <u B}
- All arithmetic is modulo 2^32; results wrap and never saturate.
- cout:
  - ops 2 and 4: carry out of bit 31 of A + B.
  - op 6: carry out of A + ~B + 1, so cout = 1 means no borrow (A >=u B).
  - all other ops: 0.
- ovf:
  - op 2: 1 when A[31] == B[31] and R[31] != A[31].
  - op 6: 1 when A[31] != B[31] and R[31] != A[31].
  - all other ops, including 4: 0.
- SLT is exact even when A - B overflows: result = (A[31] != B[31]) ? A[31] : diff[31].
- SLTU result = ~cout of A + ~B + 1.
- ze = ~|R for every op. Branch compares use op 6, so ze = (A == B).
- SLL ignores A. shamt = 0 passes B through unchanged; shamt = 31 leaves B[0] in bit 31 and zeros elsewhere.
- A ctrl change settles R and all flags within the same cycle; no glitch-free guarantee is required.
- ovf_sticky:
  - reset value 0.
  - at a rising clk edge with rst = 1, clears to 0.
  - otherwise, sets to 1 when ovf = 1.
  - otherwise holds its value.
  - rst has priority over a simultaneous overflow.
  - once set, stays set until rst.

Optional Feature:
- ALU_STICKY_OVF_EN defined: the ovf_sticky register exists as described above.
- ALU_STICKY_OVF_EN undefined: ovf_sticky is tied to 0, no flop is inferred, and clk/rst are unused (ports remain).

Decomposition:
- Package alu_pkg holds the localparams for the ctrl codes: ALU_AND = 3'd0, ALU_OR, ALU_ADD, ALU_SLT, ALU_ADDU, ALU_SLL, ALU_SUB, ALU_SLTU = 3'd7.
- The package also holds WIDTH, so get_ALUctr and the ALU share one encoding.
- One sub-module, alu_addsub: 32-bit adder with a subtract input, returning sum, cout and ovf. It is shared by ops 2, 3, 4, 6 and 7.
- Logic ops, shifter and result mux stay inline.

Test Plan:
- ctrl=2, A=32'h7FFFFFFF, B=1 -> R=32'h80000000, ovf=1, cout=0, ze=0; ovf_sticky=1 after the next edge (macro on).
- ctrl=4, A=32'hFFFFFFFF, B=1 -> R=0, ze=1, cout=1, ovf=0.
- ctrl=6, A=5, B=5 -> R=0, ze=1, cout=1, ovf=0. Then A=3, B=5 -> R=32'hFFFFFFFE, cout=0, ze=0.
- ctrl=3, A=32'h80000000, B=1 -> R=1. ctrl=7 with the same operands -> R=0.
- ctrl=5, B=32'h00000003, shamt=4 -> R=32'h30. shamt=31, B=1 -> R=32'h80000000. ctrl=0 and 1 with A=32'hF0F0, B=32'hFF00 -> R=32'hF000 and 32'hFFF0.
- Set ovf_sticky, then rst=1 in the same cycle as an overflow -> ovf_sticky=0 after the edge. With rst=0 and no overflow, it stays 0.
